// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues imem reads at PC_IF under a credit limit, tags them with
// their PC, and buffers returned words for decode over a valid/ready handshake.
module if_fetch_unit #(
  parameter int unsigned Q_DEPTH = 2,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] PC_IF,
  output logic              PC_EN,
  input  logic              FLUSH,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [DATA_W-1:0] imem_resp_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [DATA_W-1:0] inst_data
);

  localparam int unsigned CntW = $clog2(Q_DEPTH) + 1;
  localparam int unsigned PtrW = $clog2(Q_DEPTH);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  localparam cnt_t Depth = cnt_t'(Q_DEPTH);

  cnt_t outstanding_q, outstanding_d;
  cnt_t discard_q, discard_d;
  cnt_t q_count_q, q_count_d;
  ptr_t tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  ptr_t q_wr_q, q_wr_d, q_rd_q, q_rd_d;

  logic [ADDR_W-1:0] tag_mem_q  [Q_DEPTH];
  logic [ADDR_W-1:0] pc_mem_q   [Q_DEPTH];
  logic [DATA_W-1:0] data_mem_q [Q_DEPTH];

  logic fire, q_pop, q_push, drop;
  cnt_t q_avail;

  always_comb begin
    inst_valid     = ~RST & (q_count_q != '0);
    inst_pc        = pc_mem_q[q_rd_q];
    inst_data      = data_mem_q[q_rd_q];
    q_pop          = inst_valid & inst_ready;
    // A slot freed by this cycle's pop is already available as a credit, which keeps
    // single-cycle imem fetch at one instruction per cycle.
    q_avail        = q_count_q - cnt_t'(q_pop);
    imem_req_valid = ~RST & ~FLUSH &
                     (({1'b0, outstanding_q} + {1'b0, q_avail}) < {1'b0, Depth});
    imem_req_addr  = PC_IF;
    fire           = imem_req_valid & imem_req_ready;
    PC_EN          = ~RST & (fire | FLUSH);
    drop           = imem_resp_valid & (FLUSH | (discard_q != '0));
    q_push         = imem_resp_valid & ~drop;
  end

  always_comb begin
    outstanding_d = outstanding_q + cnt_t'(fire) - cnt_t'(imem_resp_valid);
    discard_d     = (drop && (discard_q != '0)) ? discard_q - cnt_t'(1) : discard_q;
    tag_wr_d      = fire   ? tag_wr_q + ptr_t'(1) : tag_wr_q;
    tag_rd_d      = q_push ? tag_rd_q + ptr_t'(1) : tag_rd_q;
    q_wr_d        = q_push ? q_wr_q + ptr_t'(1) : q_wr_q;
    q_rd_d        = q_pop  ? q_rd_q + ptr_t'(1) : q_rd_q;
    q_count_d     = q_count_q + cnt_t'(q_push) - cnt_t'(q_pop);
    if (FLUSH) begin
      // Everything still in flight after this cycle is wrong-path; that count never
      // exceeds the in-flight total, so no separate clamp is needed.
      discard_d = outstanding_q - cnt_t'(imem_resp_valid);
      tag_rd_d  = tag_wr_q;
      q_rd_d    = q_wr_q;
      q_count_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      outstanding_q <= '0;
      discard_q     <= '0;
      q_count_q     <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      q_wr_q        <= '0;
      q_rd_q        <= '0;
    end else begin
      assert (!(q_push && !q_pop && (q_count_q == Depth)));
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      q_count_q     <= q_count_d;
      tag_wr_q      <= tag_wr_d;
      tag_rd_q      <= tag_rd_d;
      q_wr_q        <= q_wr_d;
      q_rd_q        <= q_rd_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (fire) begin
      tag_mem_q[tag_wr_q] <= PC_IF;
    end
    if (q_push) begin
      pc_mem_q[q_wr_q]   <= tag_mem_q[tag_rd_q];
      data_mem_q[q_wr_q] <= imem_resp_data;
    end
  end

endmodule
